// File: rtl/quantize_offset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : quantize_offset_ctrl
//  Description : Closed-loop DC-offset controller for one 2-bit quantizer
//                channel. It counts positive-sign and large-magnitude samples
//                over windows of 2^WIN_LOG2 valid samples. At each window end
//                it steps a signed 8-bit offset so that the numbers of positive
//                and negative samples stay balanced. The offset saturates at
//                -128 and +127 and never wraps.
//  Ports       : clk            sample clock
//                reset          asynchronous active-high reset
//                i_enable       loop run (0 = idle, partial window aborted)
//                i_valid        i_y carries a sample this cycle
//                i_y            quantizer code {sign, sign^large}
//                i_freeze       keep counting, never move the offset
//                i_load         one-cycle pulse: offset <= i_load_value
//                i_load_value   signed manual offset
//                o_offset       signed offset to the quantizer
//                o_pos_count    positive samples in the last completed window
//                o_mag_count    large samples in the last completed window
//                o_update       one-cycle strobe in the window-close cycle
//                o_saturated    offset sits at -128 or +127
//  Revision    : 1.0  initial release
// ============================================================================
module quantize_offset_ctrl #(
    parameter int WIN_LOG2 = 10,
    parameter int DEADBAND = 16,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [1:0]          i_y,
    input  logic                i_freeze,
    input  logic                i_load,
    input  logic [7:0]          i_load_value,
    output logic [7:0]          o_offset,
    output logic [WIN_LOG2:0]   o_pos_count,
    output logic [WIN_LOG2:0]   o_mag_count,
    output logic                o_update,
    output logic                o_saturated
);

    localparam int DW = WIN_LOG2 + 2;

    localparam logic signed [DW-1:0] c_half     = DW'(1 << (WIN_LOG2 - 1));
    localparam logic signed [DW-1:0] c_deadband = DW'(DEADBAND);
    localparam logic signed [DW-1:0] c_neg_db   = -c_deadband;
    localparam logic signed [8:0]    c_step     = 9'(STEP);
    localparam logic signed [8:0]    c_min9     = -9'sd128;
    localparam logic signed [8:0]    c_max9     = 9'sd127;
    localparam logic [WIN_LOG2-1:0]  c_cnt_one  = WIN_LOG2'(1);
    localparam logic [WIN_LOG2:0]    c_acc_zero = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [WIN_LOG2-1:0]    r_cnt;
    logic [WIN_LOG2-1:0]    w_cnt_next;
    logic [WIN_LOG2:0]      r_pos_acc;
    logic [WIN_LOG2:0]      w_pos_next;
    logic [WIN_LOG2:0]      r_mag_acc;
    logic [WIN_LOG2:0]      w_mag_next;

    logic [7:0]             r_offset;
    logic [7:0]             w_off_next;
    logic                   r_saturated;
    logic [WIN_LOG2:0]      r_pos_count;
    logic [WIN_LOG2:0]      r_mag_count;

    logic                   w_update;
    logic                   w_is_pos;
    logic                   w_is_large;
    logic signed [DW-1:0]   w_diff;
    logic signed [8:0]      w_off_ext;
    logic signed [8:0]      w_off_dec;
    logic signed [8:0]      w_off_inc;
    logic [7:0]             w_off_dec_sat;
    logic [7:0]             w_off_inc_sat;

    // Sign is the MSB of the code; "large" codes are 01 and 10.
    assign w_is_pos   = ~i_y[1];
    assign w_is_large = i_y[1] ^ i_y[0];

    // Balance error of the closing window; one extra bit keeps N representable
    // and one more makes it signed.
    assign w_diff = $signed({1'b0, r_pos_acc}) - c_half;

    // Step in 9-bit signed arithmetic so the clamp sees the true result.
    assign w_off_ext     = $signed({r_offset[7], r_offset});
    assign w_off_dec     = w_off_ext - c_step;
    assign w_off_inc     = w_off_ext + c_step;
    assign w_off_dec_sat = (w_off_dec < c_min9) ? 8'h80 : w_off_dec[7:0];
    assign w_off_inc_sat = (w_off_inc > c_max9) ? 8'h7F : w_off_inc[7:0];

    // ------------------------------------------------------------------
    // Next-state, window accumulation and update strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pos_next   = r_pos_acc;
        w_mag_next   = r_mag_acc;
        w_update     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_pos_next = c_acc_zero;
                w_mag_next = c_acc_zero;
                if (i_enable) begin
                    w_state_next = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (i_load || !i_enable) begin
                    // A manual load or a loop stop discards the partial window.
                    w_cnt_next   = '0;
                    w_pos_next   = c_acc_zero;
                    w_mag_next   = c_acc_zero;
                    w_state_next = i_enable ? ST_ACCUM : ST_IDLE;
                end else if (i_valid) begin
                    w_cnt_next = r_cnt + c_cnt_one;
                    w_pos_next = r_pos_acc + {{WIN_LOG2{1'b0}}, w_is_pos};
                    w_mag_next = r_mag_acc + {{WIN_LOG2{1'b0}}, w_is_large};
                    if (&r_cnt) begin
                        w_state_next = ST_UPDATE;
                    end
                end
            end

            ST_UPDATE: begin
                // Samples arriving in this cycle are dropped.
                w_update     = 1'b1;
                w_cnt_next   = '0;
                w_pos_next   = c_acc_zero;
                w_mag_next   = c_acc_zero;
                w_state_next = i_enable ? ST_ACCUM : ST_IDLE;
            end

            default: begin
                w_cnt_next   = '0;
                w_pos_next   = c_acc_zero;
                w_mag_next   = c_acc_zero;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Offset update: load beats the loop; freeze only stops the loop
    // ------------------------------------------------------------------
    always_comb begin
        w_off_next = r_offset;
        if ((r_state == ST_UPDATE) && !i_freeze) begin
            if (w_diff > c_deadband) begin
                w_off_next = w_off_dec_sat;
            end else if (w_diff < c_neg_db) begin
                w_off_next = w_off_inc_sat;
            end
        end
        if (i_load) begin
            w_off_next = i_load_value;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pos_acc   <= '0;
            r_mag_acc   <= '0;
            r_offset    <= 8'h00;
            r_saturated <= 1'b0;
            r_pos_count <= '0;
            r_mag_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_pos_acc   <= w_pos_next;
            r_mag_acc   <= w_mag_next;
            r_offset    <= w_off_next;
            r_saturated <= (w_off_next == 8'h80) || (w_off_next == 8'h7F);
            if (r_state == ST_UPDATE) begin
                r_pos_count <= r_pos_acc;
                r_mag_count <= r_mag_acc;
            end
        end
    end

    assign o_offset    = r_offset;
    assign o_pos_count = r_pos_count;
    assign o_mag_count = r_mag_count;
    assign o_update    = w_update;
    assign o_saturated = r_saturated;

endmodule
`default_nettype wire

// File: tb/tb_quantize_offset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quantize_offset_ctrl
//  Description : Directed self-checking bench for quantize_offset_ctrl with
//                WIN_LOG2 = 4 (N = 16), DEADBAND = 2, STEP = 1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_quantize_offset_ctrl;

    logic       clk;
    logic       reset;
    logic       i_enable;
    logic       i_valid;
    logic [1:0] i_y;
    logic       i_freeze;
    logic       i_load;
    logic [7:0] i_load_value;
    logic [7:0] o_offset;
    logic [4:0] o_pos_count;
    logic [4:0] o_mag_count;
    logic       o_update;
    logic       o_saturated;

    int errors = 0;
    int checks = 0;

    quantize_offset_ctrl #(
        .WIN_LOG2 (4),
        .DEADBAND (2),
        .STEP     (1)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_valid      (i_valid),
        .i_y          (i_y),
        .i_freeze     (i_freeze),
        .i_load       (i_load),
        .i_load_value (i_load_value),
        .o_offset     (o_offset),
        .o_pos_count  (o_pos_count),
        .o_mag_count  (o_mag_count),
        .o_update     (o_update),
        .o_saturated  (o_saturated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n consecutive valid samples alternating ya, yb.
    task automatic feed(input logic [1:0] ya, input logic [1:0] yb, input int n);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_y     = (i % 2 == 0) ? ya : yb;
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        i_load       = 1'b1;
        i_load_value = v;
        tick();
        i_load       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (o_offset !== 8'h00 || o_pos_count !== 5'd0 || o_mag_count !== 5'd0 ||
            o_update !== 1'b0 || o_saturated !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: off=%h pos=%0d mag=%0d upd=%b sat=%b, want 00 0 0 0 0",
                     o_offset, o_pos_count, o_mag_count, o_update, o_saturated);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_all_positive();
        i_enable = 1'b1;
        tick();                         // IDLE -> ACCUM
        feed(2'b00, 2'b00, 16);
        checks++;
        if (o_update !== 1'b1 || o_offset !== 8'h00) begin
            errors++;
            $display("FAIL pos_update_cycle: upd=%b off=%h, want 1 00", o_update, o_offset);
        end
        tick();
        checks++;
        if (o_pos_count !== 5'd16 || o_mag_count !== 5'd0 || o_offset !== 8'hFF || o_update !== 1'b0) begin
            errors++;
            $display("FAIL pos_window: pos=%0d mag=%0d off=%h upd=%b, want 16 0 ff 0",
                     o_pos_count, o_mag_count, o_offset, o_update);
        end
    endtask

    task automatic test_balanced_and_negative();
        do_load(8'h00);
        feed(2'b00, 2'b11, 16);
        checks++;
        if (o_update !== 1'b1) begin
            errors++;
            $display("FAIL bal_update: upd=%b, want 1", o_update);
        end
        tick();
        checks++;
        if (o_pos_count !== 5'd8 || o_mag_count !== 5'd0 || o_offset !== 8'h00) begin
            errors++;
            $display("FAIL balanced: pos=%0d mag=%0d off=%h, want 8 0 00",
                     o_pos_count, o_mag_count, o_offset);
        end
        feed(2'b10, 2'b10, 16);
        tick();
        checks++;
        if (o_pos_count !== 5'd0 || o_mag_count !== 5'd16 || o_offset !== 8'h01) begin
            errors++;
            $display("FAIL neg_large: pos=%0d mag=%0d off=%h, want 0 16 01",
                     o_pos_count, o_mag_count, o_offset);
        end
    endtask

    task automatic test_saturation();
        do_load(8'h81);
        checks++;
        if (o_offset !== 8'h81 || o_saturated !== 1'b0) begin
            errors++;
            $display("FAIL load_81: off=%h sat=%b, want 81 0", o_offset, o_saturated);
        end
        for (int w = 0; w < 2; w++) begin
            feed(2'b01, 2'b01, 16);
            tick();
            checks++;
            if (o_offset !== 8'h80 || o_saturated !== 1'b1 || o_mag_count !== 5'd16 ||
                o_pos_count !== 5'd16) begin
                errors++;
                $display("FAIL sat_window%0d: off=%h sat=%b mag=%0d pos=%0d, want 80 1 16 16",
                         w, o_offset, o_saturated, o_mag_count, o_pos_count);
            end
        end
        do_load(8'h7F);
        checks++;
        if (o_saturated !== 1'b1) begin
            errors++;
            $display("FAIL sat_load_7f: sat=%b, want 1", o_saturated);
        end
        feed(2'b10, 2'b10, 16);
        tick();
        checks++;
        if (o_offset !== 8'h7F || o_saturated !== 1'b1) begin
            errors++;
            $display("FAIL sat_high: off=%h sat=%b, want 7f 1", o_offset, o_saturated);
        end
    endtask

    task automatic test_freeze();
        do_load(8'h10);
        i_freeze = 1'b1;
        feed(2'b00, 2'b00, 16);
        checks++;
        if (o_update !== 1'b1) begin
            errors++;
            $display("FAIL freeze_update: upd=%b, want 1", o_update);
        end
        tick();
        checks++;
        if (o_pos_count !== 5'd16 || o_offset !== 8'h10 || o_saturated !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold: pos=%0d off=%h sat=%b, want 16 10 0",
                     o_pos_count, o_offset, o_saturated);
        end
        i_freeze = 1'b0;
    endtask

    task automatic test_valid_gaps();
        int seen_at;
        do_load(8'h00);
        seen_at = -1;
        // Valid every other cycle: the 16th valid sample is at cycle 30.
        for (int i = 0; i < 40 && seen_at < 0; i++) begin
            i_valid = (i % 2 == 0);
            i_y     = 2'b00;
            tick();
            if (o_update === 1'b1) seen_at = i;
        end
        i_valid = 1'b0;
        checks++;
        if (seen_at != 30) begin
            errors++;
            $display("FAIL valid_gaps_latency: update after cycle %0d, want 30", seen_at);
        end
        tick();
        checks++;
        if (o_pos_count !== 5'd16 || o_offset !== 8'hFF) begin
            errors++;
            $display("FAIL valid_gaps_result: pos=%0d off=%h, want 16 ff", o_pos_count, o_offset);
        end
    endtask

    task automatic test_enable_abort();
        feed(2'b00, 2'b00, 7);
        i_enable = 1'b0;
        tick();
        tick();
        checks++;
        if (o_update !== 1'b0 || o_pos_count !== 5'd16 || o_offset !== 8'hFF) begin
            errors++;
            $display("FAIL abort_hold: upd=%b pos=%0d off=%h, want 0 16 ff",
                     o_update, o_pos_count, o_offset);
        end
        i_enable = 1'b1;
        tick();                         // IDLE -> ACCUM
        feed(2'b10, 2'b10, 15);
        checks++;
        if (o_update !== 1'b0) begin
            errors++;
            $display("FAIL abort_fresh_early: upd=%b after 15 samples, want 0", o_update);
        end
        feed(2'b10, 2'b10, 1);
        checks++;
        if (o_update !== 1'b1) begin
            errors++;
            $display("FAIL abort_fresh_16: upd=%b, want 1", o_update);
        end
        tick();
        checks++;
        if (o_pos_count !== 5'd0 || o_mag_count !== 5'd16 || o_offset !== 8'h00) begin
            errors++;
            $display("FAIL abort_window: pos=%0d mag=%0d off=%h, want 0 16 00",
                     o_pos_count, o_mag_count, o_offset);
        end
    endtask

    task automatic test_back_to_back_load();
        // Load arriving in the update cycle wins for offset; stats still land.
        feed(2'b00, 2'b01, 16);
        i_load       = 1'b1;
        i_load_value = 8'h22;
        tick();
        i_load       = 1'b0;
        checks++;
        if (o_offset !== 8'h22 || o_pos_count !== 5'd16 || o_mag_count !== 5'd8) begin
            errors++;
            $display("FAIL load_in_update: off=%h pos=%0d mag=%0d, want 22 16 8",
                     o_offset, o_pos_count, o_mag_count);
        end
    endtask

    task automatic test_async_reset();
        do_load(8'h05);
        feed(2'b00, 2'b00, 5);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (o_offset !== 8'h00 || o_pos_count !== 5'd0 || o_mag_count !== 5'd0 || o_update !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: off=%h pos=%0d mag=%0d upd=%b, want 00 0 0 0",
                     o_offset, o_pos_count, o_mag_count, o_update);
        end
        tick();
        reset = 1'b0;
        tick();                         // IDLE -> ACCUM
        feed(2'b00, 2'b00, 16);
        tick();
        checks++;
        if (o_pos_count !== 5'd16 || o_offset !== 8'hFF) begin
            errors++;
            $display("FAIL restart_after_reset: pos=%0d off=%h, want 16 ff", o_pos_count, o_offset);
        end
    endtask

    initial begin
        reset        = 1'b0;
        i_enable     = 1'b0;
        i_valid      = 1'b0;
        i_y          = 2'b00;
        i_freeze     = 1'b0;
        i_load       = 1'b0;
        i_load_value = 8'h00;
        #2;
        test_reset();
        test_all_positive();
        test_balanced_and_negative();
        test_saturation();
        test_freeze();
        test_valid_gaps();
        test_enable_abort();
        test_back_to_back_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quantize_offset_ctrl.md
Name: quantize_offset_ctrl

Overview:
- Closed-loop DC-offset controller for one 2-bit quantizer channel.
- Watches the quantizer output code stream over fixed windows and counts positive-sign and large-magnitude samples.
- At each window end, steps the 8-bit signed offset that feeds the quantizer's offset input so positive and negative samples stay balanced.
- Publishes per-window statistics for host readout; first step toward full AGC. One instance per RF channel, in the sample clock domain.

Parameters:
- WIN_LOG2, 10, window length N = 2^WIN_LOG2 valid samples (range 4..16).
- DEADBAND, 16, no offset change while |pos_count - N/2| <= DEADBAND.
- STEP, 1, offset change per window (1..15).

Ports:
- clk  input  1  sample clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  loop run; 0 = IDLE.
- valid  input  1  y is a valid sample this cycle.
- y  input  2  quantizer code: 00 = +small, 01 = +large, 11 = -small, 10 = -large. Sign = y[1]; large = y[1]^y[0].
- freeze  input  1  keep counting but never change offset.
- load  input  1  one-cycle pulse: offset <= load_value.
- load_value  input  8  signed manual offset.
- offset  output  8  signed offset to the quantizer.
- pos_count  output  WIN_LOG2+1  positive samples in the last completed window.
- mag_count  output  WIN_LOG2+1  large-magnitude samples in the last completed window.
- update  output  1  one-cycle strobe when pos_count/mag_count are refreshed.
- saturated  output  1  offset is at -128 or +127.

Behaviour:
- Reset: offset = 0, pos_count = 0, mag_count = 0, update = 0, saturated = 0, state IDLE, all internal counters 0.
- State IDLE:
  - Internal counters held at 0.
  - enable = 1 -> ACCUM on the next cycle.
- State ACCUM, each cycle with valid = 1:
  - sample counter increments.
  - pos_acc increments if y[1] = 0.
  - mag_acc increments if y[1]^y[0] = 1.
  - valid = 0 cycles are ignored.
  - When the N-th valid sample is accepted (counter == N-1 with valid), that sample is included and the next state is UPDATE.
- State UPDATE (exactly one cycle):
  - pos_count <= pos_acc; mag_count <= mag_acc; update = 1 during this cycle.
  - Compute diff = pos_acc - N/2 at WIN_LOG2+2 bits signed.
  - If freeze = 0 and diff > DEADBAND: offset <= max(offset - STEP, -128).
  - If freeze = 0 and diff < -DEADBAND: offset <= min(offset + STEP, +127).
  - Otherwise offset is unchanged.
  - Saturation is computed in 9-bit signed arithmetic before truncating to 8 bits. Offset never wraps.
  - Internal counters clear. Next state is ACCUM if enable = 1, else IDLE.
  - valid during the UPDATE cycle is dropped, not counted.
- enable falling in ACCUM: abort the window, clear counters, go to IDLE. Outputs keep their last values, and no update is issued.
- load (any state, highest priority):
  - offset <= load_value.
  - Partial window discarded, counters cleared.
  - From ACCUM or UPDATE, state returns to ACCUM if enable = 1, else IDLE.
  - If load coincides with an UPDATE cycle, load wins for offset, but pos_count/mag_count/update still take effect.
- Counter width: WIN_LOG2+1 bits, so pos_count can reach N (all samples positive) without overflow.
- saturated is registered and is 1 whenever the offset register is -128 or +127, including values set by load.
- Latency: offset changes on the clock edge ending the UPDATE cycle, one cycle after the final sample of the window. The quantizer sees the new offset from the next sample.
- Asynchronous reset mid-window returns everything to reset values immediately.

Test Plan:
- WIN_LOG2 = 4, DEADBAND = 2, STEP = 1. enable = 1, 16 valid samples of y = 00 -> update pulse, pos_count = 16, mag_count = 0, offset = -1 (0xFF).
- Same setup, alternating y = 00/11 for 16 samples -> pos_count = 8, offset stays 0. Then 16 samples of y = 10 -> pos_count = 0, mag_count = 16, offset = +1.
- load_value = 0x81 (-127), then two windows of all y = 01 -> offset goes -128 after the first window and stays -128 after the second; saturated = 1; mag_count = 16 both times.
- freeze = 1 with all-positive windows -> update pulses continue, pos_count = 16, offset unchanged at its loaded value 0x10.
- Samples with valid toggling 1/0 -> update only after 16 valid samples (32 cycles). Dropping enable after sample 7 and reasserting it -> no update, next window counts a fresh 16.
- Assert reset mid-window with offset = 0x05 -> offset = 0, counts = 0, no update; the loop restarts cleanly after reset deasserts.
